// File: rtl/dict_cam_dual_pkg.sv
// Shared constants and types for the runtime-loadable compression dictionary.
// Default widths here; DEPTH is always derived from the key width.
package dict_pkg;
  localparam int KEY_WIDTH_DEF = 4;
  localparam int VAL_WIDTH_DEF = 8;
  localparam int DEPTH_DEF     = 2 ** KEY_WIDTH_DEF;

  typedef logic [KEY_WIDTH_DEF-1:0] dict_key_t;
  typedef logic [VAL_WIDTH_DEF-1:0] dict_val_t;
endpackage

// File: rtl/dict_cam_dual_if.sv
// Write port plus the decompress and compress request/response channels.
// master = client side (writer/requester), slave = the dictionary.
interface dict_cam_dual_if
  import dict_pkg::*;
#(
  parameter int KEY_WIDTH = KEY_WIDTH_DEF,
  parameter int VAL_WIDTH = VAL_WIDTH_DEF
);
  logic                 wr_en;
  logic [KEY_WIDTH-1:0] wr_idx;
  logic [VAL_WIDTH-1:0] wr_val;
  logic                 clr;

  logic                 dec_req_valid;
  logic                 dec_req_ready;
  logic [KEY_WIDTH-1:0] dec_key;
  logic                 dec_rsp_valid;
  logic                 dec_rsp_ready;
  logic [VAL_WIDTH-1:0] dec_val;
  logic                 dec_hit;

  logic                 cmp_req_valid;
  logic                 cmp_req_ready;
  logic [VAL_WIDTH-1:0] cmp_val;
  logic                 cmp_rsp_valid;
  logic                 cmp_rsp_ready;
  logic [KEY_WIDTH-1:0] cmp_key;
  logic                 cmp_hit;

  modport master (
    output wr_en, wr_idx, wr_val, clr,
    output dec_req_valid, dec_key, dec_rsp_ready,
    output cmp_req_valid, cmp_val, cmp_rsp_ready,
    input  dec_req_ready, dec_rsp_valid, dec_val, dec_hit,
    input  cmp_req_ready, cmp_rsp_valid, cmp_key, cmp_hit
  );

  modport slave (
    input  wr_en, wr_idx, wr_val, clr,
    input  dec_req_valid, dec_key, dec_rsp_ready,
    input  cmp_req_valid, cmp_val, cmp_rsp_ready,
    output dec_req_ready, dec_rsp_valid, dec_val, dec_hit,
    output cmp_req_ready, cmp_rsp_valid, cmp_key, cmp_hit
  );
endinterface

// File: rtl/dict_cam_dual_prio_enc.sv
// Match vector -> {any hit, lowest set index}; index is 0 when nothing matches.
module dict_prio_enc #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic [DEPTH-1:0] match,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);
  always_comb begin
    hit = |match;
    idx = '0;
    // Scan downward so the lowest matching index is the last one assigned.
    for (int i = DEPTH - 1; i >= 0; i--)
      if (match[i]) idx = IDX_W'(i);
  end
endmodule

// File: rtl/dict_cam_dual.sv
// Dual-channel dictionary: key->value decompress and value->key compress,
// each with a one-deep stallable response register. Lookups read before write.
module dict_cam_dual
  import dict_pkg::*;
#(
  parameter int KEY_WIDTH = KEY_WIDTH_DEF,
  parameter int VAL_WIDTH = VAL_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  dict_cam_dual_if.slave       bus,
  output logic [KEY_WIDTH:0]   occupancy
);
  localparam int DEPTH = 2 ** KEY_WIDTH;

  logic [VAL_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]     vbits;
  logic [DEPTH-1:0]     match;
  logic                 enc_hit;
  logic [KEY_WIDTH-1:0] enc_idx;
  logic                 dec_acc, cmp_acc;

  assign bus.dec_req_ready = !bus.dec_rsp_valid || bus.dec_rsp_ready;
  assign bus.cmp_req_ready = !bus.cmp_rsp_valid || bus.cmp_rsp_ready;
  assign dec_acc = bus.dec_req_valid && bus.dec_req_ready;
  assign cmp_acc = bus.cmp_req_valid && bus.cmp_req_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    assign match[i] = vbits[i] && (mem[i] == bus.cmp_val);
  end

  dict_prio_enc #(.DEPTH(DEPTH), .IDX_W(KEY_WIDTH)) u_enc (
    .match (match),
    .hit   (enc_hit),
    .idx   (enc_idx)
  );

  // Value array carries no reset; only the valid bits define contents.
  always_ff @(posedge clk)
    if (!reset && bus.wr_en) mem[bus.wr_idx] <= bus.wr_val;

  always_ff @(posedge clk) begin
    if (reset) begin
      vbits     <= '0;
      occupancy <= '0;
    end else if (bus.clr) begin
      vbits <= '0;
      if (bus.wr_en) begin
        vbits[bus.wr_idx] <= 1'b1;
        occupancy         <= (KEY_WIDTH+1)'(1);
      end else begin
        occupancy <= '0;
      end
    end else if (bus.wr_en) begin
      vbits[bus.wr_idx] <= 1'b1;
      if (!vbits[bus.wr_idx]) occupancy <= occupancy + (KEY_WIDTH+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.dec_rsp_valid <= 1'b0;
      bus.dec_val       <= '0;
      bus.dec_hit       <= 1'b0;
    end else if (dec_acc) begin
      bus.dec_rsp_valid <= 1'b1;
      bus.dec_val       <= mem[bus.dec_key];
      bus.dec_hit       <= vbits[bus.dec_key];
    end else if (bus.dec_rsp_ready) begin
      bus.dec_rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.cmp_rsp_valid <= 1'b0;
      bus.cmp_key       <= '0;
      bus.cmp_hit       <= 1'b0;
    end else if (cmp_acc) begin
      bus.cmp_rsp_valid <= 1'b1;
      bus.cmp_key       <= enc_idx;
      bus.cmp_hit       <= enc_hit;
    end else if (bus.cmp_rsp_ready) begin
      bus.cmp_rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dict_cam_dual.sv
// Directed bench for dict_cam_dual: a dictionary model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_dict_cam_dual;
  import dict_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic [KEY_WIDTH_DEF:0] occupancy;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dict_cam_dual_if #(.KEY_WIDTH(KEY_WIDTH_DEF), .VAL_WIDTH(VAL_WIDTH_DEF)) bus ();

  dict_cam_dual #(.KEY_WIDTH(KEY_WIDTH_DEF), .VAL_WIDTH(VAL_WIDTH_DEF)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .occupancy (occupancy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: dictionary contents as plain arrays, responses as held records.
  dict_val_t m_val [DEPTH_DEF];
  bit        m_vld [DEPTH_DEF];
  bit        m_wr  [DEPTH_DEF];
  bit        e_dv = 0, e_dhit = 0, e_dknown = 1, e_cv = 0, e_chit = 0;
  dict_val_t e_dval = '0;
  dict_key_t e_ckey = '0;
  bit        started = 0;

  function automatic int count_valid();
    int n = 0;
    for (int i = 0; i < DEPTH_DEF; i++) n += int'(m_vld[i]);
    return n;
  endfunction

  initial for (int i = 0; i < DEPTH_DEF; i++) begin
    m_val[i] = '0; m_vld[i] = 0; m_wr[i] = 0;
  end

  always @(posedge clk) begin
    started = 1;
    if (reset) begin
      e_dv = 0; e_dval = '0; e_dhit = 0; e_dknown = 1;
      e_cv = 0; e_ckey = '0; e_chit = 0;
      for (int i = 0; i < DEPTH_DEF; i++) m_vld[i] = 0;
    end else begin
      if (bus.dec_req_valid && (!e_dv || bus.dec_rsp_ready)) begin
        e_dv = 1;
        e_dval = m_val[bus.dec_key];
        e_dhit = m_vld[bus.dec_key];
        e_dknown = m_wr[bus.dec_key];
      end else if (bus.dec_rsp_ready) e_dv = 0;
      if (bus.cmp_req_valid && (!e_cv || bus.cmp_rsp_ready)) begin
        e_cv = 1; e_chit = 0; e_ckey = '0;
        for (int i = 0; i < DEPTH_DEF; i++)
          if (!e_chit && m_vld[i] && m_val[i] == bus.cmp_val) begin
            e_chit = 1; e_ckey = dict_key_t'(i);
          end
      end else if (bus.cmp_rsp_ready) e_cv = 0;
      // Writes land after the lookups above: read-before-write.
      if (bus.clr) for (int i = 0; i < DEPTH_DEF; i++) m_vld[i] = 0;
      if (bus.wr_en) begin
        m_val[bus.wr_idx] = bus.wr_val;
        m_vld[bus.wr_idx] = 1;
        m_wr[bus.wr_idx]  = 1;
      end
    end
  end

  always @(negedge clk) if (started) begin
    chk("occupancy", 32'(occupancy), 32'(count_valid()));
    chk("dec_rsp_valid", 32'(bus.dec_rsp_valid), 32'(e_dv));
    chk("dec_req_ready", 32'(bus.dec_req_ready), 32'(!e_dv || bus.dec_rsp_ready));
    chk("dec_hit", 32'(bus.dec_hit), 32'(e_dhit));
    if (e_dknown) chk("dec_val", 32'(bus.dec_val), 32'(e_dval));
    chk("cmp_rsp_valid", 32'(bus.cmp_rsp_valid), 32'(e_cv));
    chk("cmp_req_ready", 32'(bus.cmp_req_ready), 32'(!e_cv || bus.cmp_rsp_ready));
    chk("cmp_hit", 32'(bus.cmp_hit), 32'(e_chit));
    chk("cmp_key", 32'(bus.cmp_key), 32'(e_ckey));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1;
    bus.wr_en = 0; bus.wr_idx = '0; bus.wr_val = '0; bus.clr = 0;
    bus.dec_req_valid = 0; bus.dec_key = '0; bus.dec_rsp_ready = 1;
    bus.cmp_req_valid = 0; bus.cmp_val = '0; bus.cmp_rsp_ready = 1;
    tick(); tick();
    reset = 0;
    chk("lit reset occupancy", 32'(occupancy), 0);
    chk("lit reset dec_rsp_valid", 32'(bus.dec_rsp_valid), 0);
    chk("lit reset cmp_key", 32'(bus.cmp_key), 0);

    // Duplicate value at 3 and 9
    bus.wr_en = 1; bus.wr_idx = 4'd3; bus.wr_val = 8'hA5; tick();
    bus.wr_idx = 4'd9; tick();
    bus.wr_en = 0;
    chk("lit occupancy two", 32'(occupancy), 2);

    bus.cmp_req_valid = 1; bus.cmp_val = 8'hA5; tick();
    chk("lit cmp A5 valid", 32'(bus.cmp_rsp_valid), 1);
    chk("lit cmp A5 hit", 32'(bus.cmp_hit), 1);
    chk("lit cmp A5 key", 32'(bus.cmp_key), 3);
    bus.cmp_val = 8'h11; tick();
    chk("lit cmp 11 hit", 32'(bus.cmp_hit), 0);
    chk("lit cmp 11 key", 32'(bus.cmp_key), 0);
    bus.cmp_req_valid = 0; tick();

    bus.dec_req_valid = 1; bus.dec_key = 4'd9; tick();
    chk("lit dec 9 val", 32'(bus.dec_val), 32'hA5);
    chk("lit dec 9 hit", 32'(bus.dec_hit), 1);
    bus.dec_key = 4'd4; tick();
    chk("lit dec 4 hit", 32'(bus.dec_hit), 0);
    bus.dec_req_valid = 0; tick();

    // Same-cycle write is invisible to the request accepted alongside it
    bus.wr_en = 1; bus.wr_idx = 4'd5; bus.wr_val = 8'h3C;
    bus.cmp_req_valid = 1; bus.cmp_val = 8'h3C; tick();
    bus.wr_en = 0;
    chk("lit rbw miss", 32'(bus.cmp_hit), 0);
    tick();
    chk("lit rbw next hit", 32'(bus.cmp_hit), 1);
    chk("lit rbw next key", 32'(bus.cmp_key), 5);
    bus.cmp_req_valid = 0; tick();

    // Decompress stall for 3 cycles
    bus.dec_req_valid = 1; bus.dec_key = 4'd5; bus.dec_rsp_ready = 0; tick();
    bus.dec_key = 4'd9;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lit stall ready", 32'(bus.dec_req_ready), 0);
      chk("lit stall val", 32'(bus.dec_val), 32'h3C);
      chk("lit stall valid", 32'(bus.dec_rsp_valid), 1);
    end
    bus.dec_rsp_ready = 1; bus.dec_key = 4'd3; tick();
    chk("lit b2b key3 val", 32'(bus.dec_val), 32'hA5);
    bus.dec_key = 4'd9; tick();
    chk("lit b2b key9 valid", 32'(bus.dec_rsp_valid), 1);
    chk("lit b2b key9 hit", 32'(bus.dec_hit), 1);
    bus.dec_key = 4'd5; tick();
    chk("lit b2b key5 val", 32'(bus.dec_val), 32'h3C);
    bus.dec_req_valid = 0; tick();
    chk("lit drain valid", 32'(bus.dec_rsp_valid), 0);

    // Clear and write together
    chk("lit occupancy three", 32'(occupancy), 3);
    bus.clr = 1; bus.wr_en = 1; bus.wr_idx = 4'd7; bus.wr_val = 8'h42; tick();
    bus.clr = 0; bus.wr_en = 0;
    chk("lit clr+wr occupancy", 32'(occupancy), 1);
    bus.cmp_req_valid = 1; bus.cmp_val = 8'hA5; tick();
    chk("lit post-clr A5 hit", 32'(bus.cmp_hit), 0);
    bus.cmp_val = 8'h42; tick();
    chk("lit post-clr 42 hit", 32'(bus.cmp_hit), 1);
    chk("lit post-clr 42 key", 32'(bus.cmp_key), 7);

    // Reset with a stalled compress response
    bus.cmp_rsp_ready = 0; tick();
    chk("lit held cmp valid", 32'(bus.cmp_rsp_valid), 1);
    reset = 1; tick();
    reset = 0;
    chk("lit reset drop valid", 32'(bus.cmp_rsp_valid), 0);
    chk("lit reset occupancy 0", 32'(occupancy), 0);
    bus.cmp_rsp_ready = 1; tick();
    chk("lit post-reset 42 hit", 32'(bus.cmp_hit), 0);
    bus.cmp_req_valid = 0;
    bus.dec_req_valid = 1; bus.dec_key = 4'd7; tick();
    chk("lit post-reset dec 7 hit", 32'(bus.dec_hit), 0);
    chk("lit post-reset dec 7 val", 32'(bus.dec_val), 32'h42);
    bus.dec_req_valid = 0; tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
